// File: rtl/mac_accumulator_8bit.sv
// mac_accumulator_8bit: streaming unsigned dot-product engine.
// Operand pairs arrive over valid/ready, are registered (stage 1), multiplied
// by an 8x8 unsigned array multiplier and summed into an ACC_W-bit
// accumulator (stage 2). The beat flagged last publishes sum, beat count and
// a sticky wrap flag, which are held until the consumer takes them.

module mac_mult_8x8_array (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    // Shift-and-add of the eight partial-product rows
    always_comb begin
        p = '0;
        for (int i = 0; i < 8; i++) begin
            p = p + ({8'b0, (a & {8{b[i]}})} << i);
        end
    end
endmodule

module mac_accumulator_8bit #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf
);

    // Stage 1: operand register
    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q,  s1_last_d;
    logic [7:0]       s1_a_q,     s1_a_d;
    logic [7:0]       s1_b_q,     s1_b_d;

    // Stage 2: running accumulation state
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             ovf_acc_q,  ovf_acc_d;
    logic             first_q,    first_d;

    // Result registers
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0] out_beats_q, out_beats_d;
    logic             out_ovf_q,   out_ovf_d;

    logic             accept;
    logic [15:0]      prod;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum;
    logic             ovf_n;
    logic [CNT_W-1:0] cnt_n;

    // Input is blocked while a last beat sits in stage 1 or a result is pending,
    // so a finished vector never mixes with the next one.
    assign in_ready = !rst && !out_valid_q && !(s1_valid_q && s1_last_q);
    assign accept   = in_valid && in_ready;

    mac_mult_8x8_array u_mult (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (prod)
    );

    // Stage 1 next state: capture the pair on accept, otherwise drop valid
    always_comb begin
        s1_valid_d = accept;
        s1_last_d  = s1_last_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept) begin
            s1_last_d = in_last;
            s1_a_d    = in_a;
            s1_b_d    = in_b;
        end
    end

    // Stage 2 arithmetic: the first beat of a vector starts from zero rather
    // than clearing acc explicitly, which saves a cycle between vectors.
    always_comb begin
        base  = first_q ? '0 : acc_q;
        sum   = {1'b0, base} + {{(ACC_W - 15){1'b0}}, prod};
        ovf_n = (first_q ? 1'b0 : ovf_acc_q) | sum[ACC_W];
        cnt_n = (first_q ? '0 : beat_cnt_q) + CNT_W'(1);
    end

    // Stage 2 and result next state
    always_comb begin
        acc_d       = acc_q;
        beat_cnt_d  = beat_cnt_q;
        ovf_acc_d   = ovf_acc_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (s1_valid_q) begin
            acc_d = sum[ACC_W-1:0];
            if (s1_last_q) begin
                out_data_d  = sum[ACC_W-1:0];
                out_beats_d = cnt_n;
                out_ovf_d   = ovf_n;
                out_valid_d = 1'b1;
                first_d     = 1'b1;
            end else begin
                ovf_acc_d  = ovf_n;
                beat_cnt_d = cnt_n;
                first_d    = 1'b0;
            end
        end
    end

    // State registers; reset discards any partial vector and pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            ovf_acc_q   <= 1'b0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            acc_q       <= acc_d;
            beat_cnt_q  <= beat_cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulator_8bit.sv
// Bench for mac_accumulator_8bit: a 24-bit and a 16-bit accumulator instance
// share one input stream; directed scenarios followed by a randomized stream
// checked against an exact-arithmetic reference of each vector's dot product.

module tb_mac_accumulator_8bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic        out_ready;

    logic        rdy24, ov24, ovf24;
    logic [23:0] data24;
    logic [7:0]  beats24;
    logic        rdy16, ov16, ovf16;
    logic [15:0] data16;
    logic [7:0]  beats16;

    int n_assert = 0;
    int n_fail   = 0;

    localparam int NVEC  = 150;
    localparam int LIMIT = 90000;

    longint unsigned exp_sum_q[$];
    int              exp_len_q[$];
    longint unsigned run_sum;
    longint unsigned e_sum;
    int              run_len;
    int              e_len;
    int              cur_left;
    int              vec_sent;
    int              n_results;
    int              cycles;

    always #5 clk = ~clk;

    mac_accumulator_8bit #(.ACC_W(24), .CNT_W(8)) dut24 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy24),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(ov24), .out_ready(out_ready),
        .out_data(data24), .out_beats(beats24), .out_ovf(ovf24)
    );

    mac_accumulator_8bit #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(ov16), .out_ready(out_ready),
        .out_data(data16), .out_beats(beats16), .out_ovf(ovf16)
    );

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair for exactly one edge; caller ensures in_ready is high
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        chk("beat_rdy", rdy24, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic int pick_len(input int idx);
        if (idx == 0) return 300;
        if (idx == 1) return 256;
        return int'($urandom_range(1, 300));
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        #1;
        tick(); tick();
        chk("rst_rdy",   rdy24,   0);
        chk("rst_ov",    ov24,    0);
        chk("rst_data",  data24,  0);
        chk("rst_beats", beats24, 0);
        chk("rst_ovf",   ovf24,   0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", rdy24, 1);

        // 1: three-beat vector, back-to-back
        beat(8'd3, 8'd5, 1'b0);
        beat(8'd10, 8'd20, 1'b0);
        beat(8'd255, 8'd255, 1'b1);
        chk("t1_rdy_s1last", rdy24, 0);
        chk("t1_ov_early",   ov24,  0);
        tick();
        chk("t1_ov",    ov24,    1);
        chk("t1_data",  data24,  65240);
        chk("t1_beats", beats24, 3);
        chk("t1_ovf",   ovf24,   0);
        chk("t1_rdy_ov", rdy24,  0);
        tick();
        chk("t1_ov_drop", ov24,  0);
        chk("t1_rdy_back", rdy24, 1);

        // 2: wrap in the 16-bit instance, then a clean vector
        beat(8'd255, 8'd255, 1'b0);
        beat(8'd255, 8'd255, 1'b1);
        tick();
        chk("t2_ov16",    ov16,    1);
        chk("t2_data16",  data16,  64514);
        chk("t2_beats16", beats16, 2);
        chk("t2_ovf16",   ovf16,   1);
        chk("t2_data24",  data24,  130050);
        chk("t2_ovf24",   ovf24,   0);
        tick();
        beat(8'd1, 8'd1, 1'b1);
        tick();
        chk("t2b_data16", data16, 1);
        chk("t2b_ovf16",  ovf16,  0);
        chk("t2b_beats16", beats16, 1);
        tick();

        // 3: backpressure holds the result and blocks input
        out_ready = 1'b0;
        beat(8'd7, 8'd9, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_ov_hold",   ov24,   1);
            chk("t3_data_hold", data24, 63);
            chk("t3_rdy_hold",  rdy24,  0);
            tick();
        end
        out_ready = 1'b1;
        chk("t3_rdy_pre", rdy24, 0);
        tick();
        chk("t3_ov_drop", ov24,  0);
        chk("t3_rdy_up",  rdy24, 1);
        chk("t3_data_kept", data24, 63);

        // 4: two single-beat vectors offered back to back
        beat(8'd0, 8'd200, 1'b1);
        in_valid = 1'b1; in_a = 8'd12; in_b = 8'd12; in_last = 1'b1;
        tick();
        chk("t4a_ov",    ov24,    1);
        chk("t4a_data",  data24,  0);
        chk("t4a_beats", beats24, 1);
        chk("t4a_rdy",   rdy24,   0);
        tick();
        chk("t4_ov_drop", ov24,  0);
        chk("t4_rdy",     rdy24, 1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        chk("t4b_ov",    ov24,    1);
        chk("t4b_data",  data24,  144);
        chk("t4b_beats", beats24, 1);
        tick();

        // 5: reset in the middle of a vector
        beat(8'd100, 8'd100, 1'b0);
        beat(8'd50, 8'd50, 1'b0);
        rst = 1'b1;
        tick();
        chk("t5_rdy_in_rst", rdy24,   0);
        chk("t5_ov_rst",     ov24,    0);
        chk("t5_data_rst",   data24,  0);
        chk("t5_beats_rst",  beats24, 0);
        rst = 1'b0;
        tick();
        chk("t5_ov_after",   ov24,    0);
        chk("t5_data_after", data24,  0);
        chk("t5_ovf_after",  ovf24,   0);
        beat(8'd2, 8'd3, 1'b1);
        tick();
        chk("t5_data",  data24,  6);
        chk("t5_beats", beats24, 1);
        chk("t5_ovf",   ovf24,   0);
        tick();
        chk("t5_ov_drop", ov24, 0);

        // 6: random stalls on both sides, many vectors
        run_sum = 0; run_len = 0; vec_sent = 0; n_results = 0; cycles = 0;
        cur_left = pick_len(0);
        while ((vec_sent < NVEC || exp_sum_q.size() > 0 || ov24) && cycles < LIMIT) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (vec_sent < NVEC && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_a     = 8'($urandom);
                in_b     = 8'($urandom);
                in_last  = (cur_left == 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end

            if (rdy16 !== rdy24 || ov16 !== ov24) chk("rnd_inst_sync", {rdy16, ov16}, {rdy24, ov24});

            if (ov24 && out_ready) begin
                if (exp_sum_q.size() == 0) begin
                    chk("rnd_extra_result", 1, 0);
                end else begin
                    e_sum = exp_sum_q.pop_front();
                    e_len = exp_len_q.pop_front();
                    chk("rnd_data24",  data24,  e_sum % (64'd1 << 24));
                    chk("rnd_data16",  data16,  e_sum % (64'd1 << 16));
                    chk("rnd_beats",   beats24, longint'(e_len % 256));
                    chk("rnd_beats16", beats16, longint'(e_len % 256));
                    chk("rnd_ovf24",   ovf24,   (e_sum >= (64'd1 << 24)) ? 1 : 0);
                    chk("rnd_ovf16",   ovf16,   (e_sum >= (64'd1 << 16)) ? 1 : 0);
                    n_results++;
                end
            end

            if (in_valid && rdy24) begin
                run_sum += longint'(in_a) * longint'(in_b);
                run_len++;
                cur_left--;
                if (in_last) begin
                    exp_sum_q.push_back(run_sum);
                    exp_len_q.push_back(run_len);
                    run_sum = 0;
                    run_len = 0;
                    vec_sent++;
                    cur_left = pick_len(vec_sent);
                end
            end

            tick();
            cycles++;
        end
        in_valid = 1'b0;
        if (cycles >= LIMIT) chk("rnd_timeout", cycles, 0);
        chk("rnd_result_count", n_results, NVEC);
        chk("rnd_queue_empty", exp_sum_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
